// File: rtl/pipeline_debug_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_debug_ctrl
// Brief    : Byte-stream debug sequencer for the 5-stage pipeline: program
//            load, run/step control and PC/register/memory dump to the host.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_debug_ctrl #(
   parameter int INST_SZ  = 32,
   parameter int PC_SZ    = 32,
   parameter int REG_SZ   = 5,
   parameter int MAX_INST = 256
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic [7:0]         i_rx_data,
   input  logic               i_rx_valid,
   output logic [7:0]         o_tx_data,
   output logic               o_tx_start,
   input  logic               i_tx_done,
   output logic               o_write,
   output logic [INST_SZ-1:0] o_instruction,
   output logic               o_enable,
   output logic [REG_SZ-1:0]  o_debug_addr,
   input  logic [PC_SZ-1:0]   i_pc,
   input  logic [INST_SZ-1:0] i_reg,
   input  logic [INST_SZ-1:0] i_mem,
   input  logic               i_halt,
   output logic               o_busy
);
   localparam int c_CNT_W = $clog2(MAX_INST) + 1;
   localparam int c_WI_W  = REG_SZ + 2;
   localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(MAX_INST - 1);
   localparam logic [c_WI_W-1:0]  c_WORD_REGS = c_WI_W'(2 ** REG_SZ);
   localparam logic [c_WI_W-1:0]  c_WORD_LAST = c_WI_W'(2 * (2 ** REG_SZ));

   localparam logic [7:0] c_CMD_LOAD = 8'h4C;
   localparam logic [7:0] c_CMD_RUN  = 8'h43;
   localparam logic [7:0] c_CMD_STEP = 8'h53;

   localparam logic [2:0] c_ST_IDLE      = 3'd0;
   localparam logic [2:0] c_ST_LOAD      = 3'd1;
   localparam logic [2:0] c_ST_WRITE     = 3'd2;
   localparam logic [2:0] c_ST_RUN       = 3'd3;
   localparam logic [2:0] c_ST_STEP      = 3'd4;
   localparam logic [2:0] c_ST_DUMP_SEL  = 3'd5;
   localparam logic [2:0] c_ST_DUMP_SEND = 3'd6;
   localparam logic [2:0] c_ST_DUMP_WAIT = 3'd7;

   logic [2:0]         r_state;
   logic [2:0]         w_state_nxt;
   logic               r_halted;
   logic [c_CNT_W-1:0] r_count;
   logic [INST_SZ-9:0] r_shift;
   logic [INST_SZ-1:0] r_instruction;
   logic [1:0]         r_byte_cnt;
   logic [c_WI_W-1:0]  r_word_idx;
   logic [INST_SZ-1:0] r_tx_word;
   logic               r_settle;
   logic               r_step_chk;

   logic               w_rx;
   logic [INST_SZ-1:0] w_load_word;
   logic [INST_SZ-1:0] w_word;

   // A received byte coinciding with a transmit-done is treated as noise.
   assign w_rx        = i_rx_valid & ~i_tx_done;
   assign w_load_word = {r_shift, i_rx_data};
   assign w_word      = (r_word_idx == '0)          ? INST_SZ'(i_pc) :
                        (r_word_idx <= c_WORD_REGS) ? i_reg : i_mem;

   // Word 0 is the PC; the register and memory sweeps both start from address 0.
   assign o_debug_addr  = (r_word_idx == '0) ? '0 : REG_SZ'(r_word_idx - c_WI_W'(1));
   assign o_tx_data     = r_tx_word[INST_SZ-1 -: 8];
   assign o_instruction = r_instruction;

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) r_state <= c_ST_IDLE;
      else          r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_ST_IDLE: begin
            if (w_rx) begin
               if (i_rx_data == c_CMD_LOAD)                   w_state_nxt = c_ST_LOAD;
               else if (i_rx_data == c_CMD_RUN  && !r_halted) w_state_nxt = c_ST_RUN;
               else if (i_rx_data == c_CMD_STEP && !r_halted) w_state_nxt = c_ST_STEP;
            end
         end
         c_ST_LOAD:  if (w_rx && r_byte_cnt == 2'd3) w_state_nxt = c_ST_WRITE;
         c_ST_WRITE: begin
            if (r_instruction == {INST_SZ{1'b1}} || r_count == c_CNT_LAST) w_state_nxt = c_ST_IDLE;
            else                                                           w_state_nxt = c_ST_LOAD;
         end
         c_ST_RUN:       if (i_halt) w_state_nxt = c_ST_DUMP_SEL;
         c_ST_STEP:      w_state_nxt = c_ST_DUMP_SEL;
         c_ST_DUMP_SEL:  if (r_settle) w_state_nxt = c_ST_DUMP_SEND;
         c_ST_DUMP_SEND: w_state_nxt = c_ST_DUMP_WAIT;
         c_ST_DUMP_WAIT: begin
            if (i_tx_done) begin
               if (r_byte_cnt != 2'd3)             w_state_nxt = c_ST_DUMP_SEND;
               else if (r_word_idx == c_WORD_LAST) w_state_nxt = c_ST_IDLE;
               else                                w_state_nxt = c_ST_DUMP_SEL;
            end
         end
         default: w_state_nxt = c_ST_IDLE;
      endcase
   end

   always_comb begin
      o_enable   = 1'b0;
      o_write    = 1'b0;
      o_tx_start = 1'b0;
      o_busy     = 1'b1;
      case (r_state)
         c_ST_IDLE:           o_busy     = 1'b0;
         c_ST_RUN, c_ST_STEP: o_enable   = 1'b1;
         c_ST_WRITE:          o_write    = 1'b1;
         c_ST_DUMP_SEND:      o_tx_start = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_halted      <= 1'b0;
         r_count       <= '0;
         r_shift       <= '0;
         r_instruction <= '0;
         r_byte_cnt    <= '0;
         r_word_idx    <= '0;
         r_tx_word     <= '0;
         r_settle      <= 1'b0;
         r_step_chk    <= 1'b0;
      end else begin
         case (r_state)
            c_ST_IDLE: begin
               if (w_rx && i_rx_data == c_CMD_LOAD) begin
                  r_halted   <= 1'b0;
                  r_count    <= '0;
                  r_byte_cnt <= '0;
               end
            end
            c_ST_LOAD: begin
               if (w_rx) begin
                  r_shift    <= w_load_word[INST_SZ-9:0];
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  if (r_byte_cnt == 2'd3) r_instruction <= w_load_word;
               end
            end
            c_ST_WRITE: r_count    <= r_count + c_CNT_W'(1);
            c_ST_RUN:   if (i_halt) r_halted <= 1'b1;
            c_ST_STEP:  r_step_chk <= 1'b1;
            c_ST_DUMP_SEL: begin
               // Halt from the stepped instruction shows up one cycle after the enable.
               r_step_chk <= 1'b0;
               if (r_step_chk && i_halt) r_halted <= 1'b1;
               r_settle <= ~r_settle;
               if (r_settle) begin
                  r_tx_word  <= w_word;
                  r_byte_cnt <= '0;
               end
            end
            c_ST_DUMP_WAIT: begin
               if (i_tx_done) begin
                  r_byte_cnt <= r_byte_cnt + 2'd1;
                  r_tx_word  <= r_tx_word << 8;
                  if (r_byte_cnt == 2'd3)
                     r_word_idx <= (r_word_idx == c_WORD_LAST) ? '0 : r_word_idx + c_WI_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/pipeline_debug_ctrl.md
# pipeline_debug_ctrl

Debug controller that sequences the 5-stage MIPS pipeline from a byte-stream host link, typically a UART RX/TX pair. It loads the program through the pipeline's instruction-write port and runs the pipeline either continuously until halt or one clock at a time. After each run or step it dumps PC, register file and data memory back to the host by sweeping the pipeline's debug address. It sits between the UART and the pipeline top and is the only driver of the pipeline's `i_write`, `i_enable`, `i_instruction` and `i_debug_addr`.

## Interface
- `INST_SZ`, 32, instruction/data word width
- `PC_SZ`, 32, PC width
- `REG_SZ`, 5, debug address width (32 regs / 32 mem words)
- `MAX_INST`, 256, maximum instructions accepted per load
- `i_clk` in 1: single clock
- `i_reset` in 1: asynchronous, active-low reset
- `i_rx_data` in 8: received byte
- `i_rx_valid` in 1: one-cycle pulse; `i_rx_data` valid
- `o_tx_data` out 8: byte to transmit
- `o_tx_start` out 1: one-cycle pulse; transmitter latches `o_tx_data`
- `i_tx_done` in 1: one-cycle pulse; transmitter is ready for the next byte
- `o_write` out 1: instruction-memory write strobe to the pipeline
- `o_instruction` out INST_SZ: instruction word to the pipeline
- `o_enable` out 1: pipeline clock enable
- `o_debug_addr` out REG_SZ: debug read address, shared by registers and memory
- `i_pc` in PC_SZ, `i_reg` in INST_SZ, `i_mem` in INST_SZ: pipeline debug read data
- `i_halt` in 1: pipeline halt, from the MEM/WB stage
- `o_busy` out 1: high in any state other than IDLE

## Operation
- **States:** IDLE, LOAD, WRITE, RUN, STEP, DUMP_SEL, DUMP_SEND, DUMP_WAIT.
- **IDLE:** decode on `i_rx_valid`.
  - 0x4C 'L' → LOAD. Clears the halted flag and the instruction counter.
  - 0x43 'C' → RUN.
  - 0x53 'S' → STEP.
  - Any other byte is ignored.
  - 'C' and 'S' are ignored while the halted flag is set.
- **LOAD:**
  - Shift in 4 bytes, MSB first.
  - On the 4th byte → WRITE.
- **WRITE** (1 cycle):
  - `o_instruction` = assembled word, `o_write` = 1, counter++.
  - If the word is 32'hFFFF_FFFF (HALT) or the counter reaches `MAX_INST` → IDLE; otherwise → LOAD.
- **RUN:**
  - `o_enable` = 1 every cycle.
  - On `i_halt` = 1: set the halted flag, `o_enable` = 0 the next cycle → DUMP_SEL.
- **STEP:**
  - `o_enable` = 1 for exactly one cycle → DUMP_SEL.
  - If `i_halt` is sampled 1 in the cycle after the step, set the halted flag.
- **Dump sequence:** 65 words, 4 bytes each MSB first, 260 bytes total.
  - Word 0 is `i_pc`.
  - Words 1–32 are `i_reg` at addresses 0..31.
  - Words 33–64 are `i_mem` at addresses 0..31.
- **DUMP_SEL:** drive `o_debug_addr`; wait 1 settle cycle; latch the word → DUMP_SEND.
- **DUMP_SEND:** `o_tx_data` = current byte, `o_tx_start` pulse → DUMP_WAIT.
- **DUMP_WAIT:** on `i_tx_done`, go to the next byte (→ DUMP_SEND) or the next word (→ DUMP_SEL). After word 64 → IDLE with `o_debug_addr` = 0.
- `o_enable` = 0 in every state except RUN and STEP. The pipeline does not advance during a dump.
- `i_rx_valid` is ignored in RUN, STEP and all DUMP states; bytes are dropped, not queued.

## Timing
- **Reset values:** all outputs 0; state IDLE; halted flag 0; counter 0; shift register 0.
- **Reset mid-operation:** immediate return to reset values, including mid-dump and mid-load. A partial word is discarded and no `o_write` is issued.
- **Command latency:** `i_rx_valid` at cycle N → state change at N+1. `o_enable` is first high at N+1 for RUN/STEP.
- **Load:** 4th byte `i_rx_valid` at cycle N → `o_write` = 1 at N+1 only. `o_instruction` holds its value until the next WRITE.
- **STEP:** `o_enable` is high in exactly one cycle. The first `o_tx_start` follows no earlier than 2 cycles later (DUMP_SEL plus settle).
- **RUN:** `o_enable` is registered. Pipeline halt at cycle N → `o_enable` = 0 at N+1 → dump starts.
- **Transmit handshake:** `o_tx_start` is a single-cycle pulse and is never issued while a `i_tx_done` is outstanding.
- **Simultaneous events:** `i_tx_done` in DUMP_SEND, without a prior start, is ignored. `i_rx_valid` coinciding with `i_tx_done` is ignored.
- **Counter width:** clog2(`MAX_INST`)+1 bits; it never wraps.
- **Debug address:** `o_debug_addr` wraps 31→0 between the register and memory phases.

## Test plan
- **Reset:** hold `i_reset` = 0 → all outputs 0. Release; send 0x41 → no output change; `o_busy` stays 0.
- **Load:** send 'L', 00 00 00 01, FF FF FF FF → two `o_write` pulses carrying 0x0000_0001 then 0xFFFF_FFFF. State returns to IDLE; `o_enable` never rises.
- **Load overflow:** with `MAX_INST` = 4, send 'L' + 20 bytes → exactly 4 `o_write` pulses. The last 4 bytes are ignored.
- **Step:** `i_pc` = 0x0000_0004, `i_reg` = {27'b0, addr}. Send 'S' → `o_enable` high for 1 cycle. Then 260 TX bytes: the first 4 are 00 00 00 04, and the bytes for reg 5 are 00 00 00 05. `o_debug_addr` sweeps 0..31 twice.
- **Run:** send 'C'; assert `i_halt` 10 cycles later → `o_enable` high 10 cycles then 0, followed by a 260-byte dump. A subsequent 'S' or 'C' gives no `o_enable` and no TX. 'L' clears the halted flag.
- **Reset mid-dump:** pulse `i_reset` low after byte 100 → no further `o_tx_start`; all outputs 0. A new 'S' produces a full 260-byte dump.
